pdp8_mem_arbiter: RTL

PDP8_MEM_ARBITER -- requirements
Module: pdp8_mem_arbiter

---
 rtl/pdp8_mem_arbiter_pkg.sv | 48 ++++
 rtl/pdp8_mem_arbiter_rr_arb2.sv | 58 +++++
 rtl/pdp8_mem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pdp8_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pdp8_mem_arbiter_pkg
//
// Shared definitions for the PDP-8 memory arbiter slice:
//   word_t                 - 12-bit PDP-8 machine word
//   arb_state_t            - transaction FSM states
//   port_id_t              - requester identity (CPU = 0, loader/front panel = 1)
//   DEFAULT_TIMEOUT_CYCLES - default WAIT-state abort limit
//   rr_pick()              - two-way round-robin selection
// ---------------------------------------------------------------------------
package pdp8_mem_arbiter_pkg;

  localparam int WORD_W = 12;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t WORD_ZERO = 12'o0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_id_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  // A lone requester always wins. On a tie the port that was not granted
  // last goes next, so neither side can starve the other.
  function automatic port_id_t rr_pick(input logic     cpu_req,
                                       input logic     ldr_req,
                                       input port_id_t last);
    port_id_t pick;
    pick = PORT_CPU;
    if (cpu_req && ldr_req) begin
      pick = (last == PORT_CPU) ? PORT_LDR : PORT_CPU;
    end else if (ldr_req) begin
      pick = PORT_LDR;
    end
    return pick;
  endfunction

endpackage

// File: rtl/pdp8_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Two-way round-robin picker for the PDP-8 memory arbiter. The pick is purely
// combinational from the current requests and the registered last-granted
// pointer; the pointer only moves when the owning FSM says a transaction has
// completed.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   cpu_req      - request from the CPU port
//   ldr_req      - request from the loader / front-panel port
//   update       - load update_port into the last-granted pointer
//   update_port  - port that just completed its transaction
//   any_req      - at least one request is pending
//   pick         - port that would win if granted now
// ---------------------------------------------------------------------------
module rr_arb2
  import pdp8_mem_arbiter_pkg::*;
#(
  parameter bit RESET_LAST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cpu_req,
  input  logic     ldr_req,
  input  logic     update,
  input  port_id_t update_port,
  output logic     any_req,
  output port_id_t pick
);

  port_id_t last_q;
  port_id_t last_d;

  // The pointer records who finished last; it holds between transactions so
  // the next tie goes to the other side.
  always_comb begin
    last_d = last_q;
    if (update) begin
      last_d = update_port;
    end
  end

  // RESET_LAST = 1 makes the loader look like the previous winner, which
  // hands the first tie after reset to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= port_id_t'(RESET_LAST);
    end else begin
      last_q <= last_d;
    end
  end

  assign any_req = cpu_req | ldr_req;
  assign pick    = rr_pick(cpu_req, ldr_req, last_q);

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pdp8_mem_arbiter
//
// Shares one memory controller between the PDP-8 CPU (port 0) and the
// loader / front panel (port 1). Each transaction walks IDLE -> ISSUE ->
// WAIT -> RESP; the request that wins in IDLE has its we/addr/wdata latched,
// the strobe is held through WAIT until mem_done, and the owner gets a single
// ack pulse in RESP. A WAIT that runs TIMEOUT_CYCLES cycles without mem_done
// is aborted: the strobe drops, rdata is zeroed and timeout_err pulses
// alongside the ack.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    - CPU request, held until cpu_ack
//   cpu_ack                  - one-cycle completion pulse to the CPU
//   ldr_req/we/addr/wdata    - loader request, held until ldr_ack
//   ldr_ack                  - one-cycle completion pulse to the loader
//   rdata                    - read data, valid in the ack cycle
//   mem_rd_en, mem_wr_en     - strobes to the memory controller
//   mem_addr, mem_wdata      - latched address and write data
//   mem_rdata, mem_done      - memory read data and completion pulse
//   busy                     - any state other than IDLE
//   owner                    - port of the current or most recent grant
//   timeout_err              - one-cycle pulse on a timeout abort
// ---------------------------------------------------------------------------
module pdp8_mem_arbiter
  import pdp8_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter bit          RESET_LAST     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [WORD_W-1:0] ldr_addr,
  input  logic [WORD_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);

  // The counter has to be able to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  arb_state_t       state_q,   state_d;
  port_id_t         owner_q,   owner_d;
  logic             we_q,      we_d;
  word_t            addr_q,    addr_d;
  word_t            wdata_q,   wdata_d;
  word_t            rdata_q,   rdata_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             timeout_q, timeout_d;

  logic             any_req;
  port_id_t         pick;
  logic             arb_update;
  logic [CNT_W-1:0] cnt_inc;
  logic             strobe_active;

  rr_arb2 #(
    .RESET_LAST (RESET_LAST)
  ) u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .update      (arb_update),
    .update_port (owner_q),
    .any_req     (any_req),
    .pick        (pick)
  );

  // Saturating increment so the counter can never wrap back under the limit.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and datapath latches. Requests are only looked at in IDLE, so
  // a request still high during RESP waits for the next IDLE cycle, and
  // mem_done only matters in WAIT. In WAIT a real mem_done beats a timeout
  // landing on the same cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          state_d = ST_ISSUE;
          owner_d = pick;
          if (pick == PORT_CPU) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            we_d    = ldr_we;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (mem_done) begin
          state_d = ST_RESP;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            state_d   = ST_RESP;
            timeout_d = 1'b1;
            rdata_d   = WORD_ZERO;
          end
        end
      end

      ST_RESP: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        arb_update = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state clears asynchronously so a reset in the middle of WAIT pulls
  // the strobes and busy down without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_CPU;
      we_q      <= 1'b0;
      addr_q    <= WORD_ZERO;
      wdata_q   <= WORD_ZERO;
      rdata_q   <= WORD_ZERO;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Strobes, acks and busy decode straight from registered state. timeout_q
  // is only ever set on the WAIT->RESP edge, so it lines up with the ack.
  assign strobe_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign mem_rd_en     = strobe_active & ~we_q;
  assign mem_wr_en     = strobe_active &  we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign rdata         = rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign owner         = owner_q;
  assign cpu_ack       = (state_q == ST_RESP) && (owner_q == PORT_CPU);
  assign ldr_ack       = (state_q == ST_RESP) && (owner_q == PORT_LDR);
  assign timeout_err   = timeout_q;

endmodule
